debounce_filter: RTL and testbench

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

---
 rtl/debounce_filter.sv | 108 ++++++++++
 tb/tb_debounce_filter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// Multi-channel input debouncer: 2-flop synchroniser, prescaled sampling into a
// per-channel history, then unanimous or majority decision with edge pulses.
module debounce_filter #(
  parameter int              Size            = 3,
  parameter int              Number          = 4,
  parameter int              Mode            = 0,
  parameter int              ClockPeriod_ns  = 20,
  parameter int              FilterPeriod_ns = 500_000,
  parameter logic [Size-1:0] InitValue       = '1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [Size-1:0] I,
  input  logic            Hold,
  output logic [Size-1:0] O,
  output logic [Size-1:0] Rise,
  output logic [Size-1:0] Fall,
  output logic            Changed,
  output logic            Strobe
);

  localparam int Prescale = FilterPeriod_ns / ClockPeriod_ns / (Number - 1);
  localparam int Majority = (Number + 1) / 2;

  if (Size < 1 || Size > 32) begin : g_bad_size
    $error("debounce_filter: Size must be 1..32");
  end
  if (Number < 2 || Number > 16) begin : g_bad_number
    $error("debounce_filter: Number must be 2..16");
  end
  if (Mode != 0 && Mode != 1) begin : g_bad_mode
    $error("debounce_filter: Mode must be 0 or 1");
  end
  if (Mode == 1 && (Number < 3 || (Number % 2) == 0)) begin : g_bad_majority
    $error("debounce_filter: majority mode needs odd Number >= 3");
  end

  logic            tick;
  logic [Size-1:0] sync1;
  logic [Size-1:0] sync2;
  logic [Size-1:0] next_o;
  logic [Size-1:0] rise_d;
  logic [Size-1:0] fall_d;

  // The prescaler free-runs through Hold so the sample grid never slips.
  if (Prescale > 1) begin : g_prescale
    localparam int CntW = $clog2(Prescale);
    localparam logic [CntW-1:0] CntLast = CntW'(Prescale - 1);
    logic [CntW-1:0] cnt;

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)               cnt <= '0;
      else if (cnt == CntLast) cnt <= '0;
      else                     cnt <= cnt + CntW'(1);
    end

    assign tick = (cnt == CntLast);
  end else begin : g_no_prescale
    assign tick = 1'b1;
  end

  assign Strobe = tick & ~Hold;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1 <= InitValue;
      sync2 <= InitValue;
    end else begin
      sync1 <= I;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < Size; i++) begin : g_ch
    logic [Number-1:0] hist;

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)       hist <= {Number{InitValue[i]}};
      else if (Strobe) hist <= {hist[Number-2:0], sync2[i]};
    end

    // Decision uses the history as held before this strobe's shift.
    if (Mode == 0) begin : g_unanimous
      assign next_o[i] = (hist == '0) ? 1'b0 :
                         (&hist)      ? 1'b1 : O[i];
    end else begin : g_majority
      assign next_o[i] = ($countones(hist) >= Majority);
    end
  end

  assign rise_d = Strobe ? (next_o & ~O) : '0;
  assign fall_d = Strobe ? (~next_o & O) : '0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      O       <= InitValue;
      Rise    <= '0;
      Fall    <= '0;
      Changed <= 1'b0;
    end else begin
      if (Strobe) O <= next_o;
      Rise    <= rise_d;
      Fall    <= fall_d;
      Changed <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: three configurations driven side by side and
// compared each cycle against a sample-list reference model.
module tb_debounce_filter;

  logic       Clock = 1'b0;
  logic       rst;
  logic [2:0] iv [3];
  logic       hv [3];

  logic [2:0] oa, ra, fa, ob, rb, fb, oc, rc, fc;
  logic       ca, sa, cb, sb, cc, sc;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  debounce_filter #(.Size(3), .Number(4), .Mode(0), .ClockPeriod_ns(20),
                    .FilterPeriod_ns(60), .InitValue(3'b111)) dut_a (
    .Clock(Clock), .Reset(rst), .I(iv[0]), .Hold(hv[0]),
    .O(oa), .Rise(ra), .Fall(fa), .Changed(ca), .Strobe(sa));

  debounce_filter #(.Size(3), .Number(4), .Mode(0), .ClockPeriod_ns(20),
                    .FilterPeriod_ns(600), .InitValue(3'b111)) dut_b (
    .Clock(Clock), .Reset(rst), .I(iv[1]), .Hold(hv[1]),
    .O(ob), .Rise(rb), .Fall(fb), .Changed(cb), .Strobe(sb));

  debounce_filter #(.Size(3), .Number(5), .Mode(1), .ClockPeriod_ns(20),
                    .FilterPeriod_ns(80), .InitValue(3'b101)) dut_c (
    .Clock(Clock), .Reset(rst), .I(iv[2]), .Hold(hv[2]),
    .O(oc), .Rise(rc), .Fall(fc), .Changed(cc), .Strobe(sc));

  // Reference model: each instance keeps the list of values it sampled;
  // a sample taken at edge k is the input seen two edges earlier.
  int         numb [3];
  int         mode [3];
  int         pre  [3];
  logic [2:0] init [3];
  bit         raw  [3][3][2];
  bit         smp  [3][3][4096];
  int         nsmp [3];
  int         ecnt [3];
  logic [2:0] eo [3], er [3], ef [3];
  logic       ec [3];

  task automatic model_reset(input int k);
    for (int ch = 0; ch < 3; ch++) begin
      raw[k][ch][0] = init[k][ch];
      raw[k][ch][1] = init[k][ch];
      for (int j = 0; j < numb[k]; j++) smp[k][ch][j] = init[k][ch];
    end
    nsmp[k] = numb[k];
    ecnt[k] = 0;
    eo[k] = init[k];
    er[k] = '0;
    ef[k] = '0;
    ec[k] = 1'b0;
  endtask

  task automatic model_edge(input int k);
    bit tick, stb, nv;
    int ones;
    tick = (pre[k] <= 1) || ((ecnt[k] % pre[k]) == pre[k] - 1);
    ecnt[k]++;
    stb = tick && !hv[k];
    er[k] = '0;
    ef[k] = '0;
    for (int ch = 0; ch < 3; ch++) begin
      if (stb) begin
        ones = 0;
        for (int j = 0; j < numb[k]; j++) ones += int'(smp[k][ch][(nsmp[k] - 1 - j) % 4096]);
        if (mode[k] == 1)    nv = (2 * ones > numb[k]);
        else if (ones == 0)  nv = 1'b0;
        else if (ones == numb[k]) nv = 1'b1;
        else                 nv = eo[k][ch];
        er[k][ch] = nv && !eo[k][ch];
        ef[k][ch] = !nv && eo[k][ch];
        eo[k][ch] = nv;
        smp[k][ch][nsmp[k] % 4096] = raw[k][ch][0];
      end
      raw[k][ch][0] = raw[k][ch][1];
      raw[k][ch][1] = iv[k][ch];
    end
    if (stb) nsmp[k]++;
    ec[k] = |(er[k] | ef[k]);
  endtask

  function automatic logic exp_stb(input int k);
    return ((pre[k] <= 1) || ((ecnt[k] % pre[k]) == pre[k] - 1)) && !hv[k];
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic [2:0] o, input logic [2:0] r,
                            input logic [2:0] f, input logic c, input logic s);
    chk("O", k, 32'(o), 32'(eo[k]));
    chk("Rise", k, 32'(r), 32'(er[k]));
    chk("Fall", k, 32'(f), 32'(ef[k]));
    chk("Changed", k, 32'(c), 32'(ec[k]));
    chk("Strobe", k, 32'(s), 32'(exp_stb(k)));
  endtask

  task automatic check_all();
    check_inst(0, oa, ra, fa, ca, sa);
    check_inst(1, ob, rb, fb, cb, sb);
    check_inst(2, oc, rc, fc, cc, sc);
  endtask

  task automatic step();
    @(posedge Clock);
    for (int k = 0; k < 3; k++) begin
      if (rst) model_reset(k);
      else     model_edge(k);
    end
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) model_reset(k);
    check_all();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit [9:0] seq;
    int       ch;
    numb = '{4, 4, 5};
    mode = '{0, 0, 1};
    pre  = '{1, 10, 1};
    init = '{3'b111, 3'b111, 3'b101};
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = init[k];
      hv[k] = 1'b0;
    end

    // Asynchronous reset, checked before any clock edge.
    #1;
    for (int k = 0; k < 3; k++) model_reset(k);
    check_all();
    chk("reset_o", 0, 32'(oa), 32'h7);
    chk("reset_o", 2, 32'(oc), 32'h5);
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) step();
    chk("strobe_every_cycle", 0, 32'(sa), 32'h1);

    // Step on channel 0: stable before E0, output must move at E6 exactly.
    iv[0][0] = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      step();
      if (e < 6)  chk("latency_hold", 0, 32'(oa), 32'h7);
      if (e == 6) begin
        chk("latency_o", 0, 32'(oa), 32'h6);
        chk("latency_fall", 0, 32'(fa), 32'h1);
        chk("latency_changed", 0, 32'(ca), 32'h1);
      end
      if (e == 7) chk("fall_once", 0, 32'(fa), 32'h0);
    end
    iv[0][0] = 1'b1;
    for (int n = 0; n < 8; n++) step();
    chk("recover_o", 0, 32'(oa), 32'h7);

    // A 3-cycle glitch is shorter than the history and must be rejected.
    iv[0][1] = 1'b0;
    for (int n = 0; n < 3; n++) step();
    iv[0][1] = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      chk("glitch_o", 0, 32'(oa), 32'h7);
      chk("glitch_edges", 0, 32'(ra | fa), 32'h0);
    end

    // Prescale 10 with a 25-cycle Hold window.
    pulse_reset();
    for (int c = 1; c <= 70; c++) begin
      hv[1] = (c >= 13 && c <= 37);
      if (c == 14) iv[1] = 3'b010;
      step();
      if (c == 9)  chk("presc_strobe_10", 1, 32'(sb), 32'h1);
      if (c == 19) chk("hold_strobe_20", 1, 32'(sb), 32'h0);
      if (c == 29) chk("hold_strobe_30", 1, 32'(sb), 32'h0);
      if (c == 39) chk("presc_strobe_40", 1, 32'(sb), 32'h1);
      if (c >= 14 && c <= 37) chk("hold_frozen", 1, 32'(ob), 32'h7);
    end
    hv[1] = 1'b0;

    // Majority of 5: histories 10110 then 00101 on channel 1.
    seq = 10'b1011000101;
    for (int n = 0; n <= 12; n++) begin
      iv[2][1] = (n <= 9) ? seq[9-n] : 1'b1;
      step();
      if (n == 7)  chk("majority_high", 2, 32'(oc[1]), 32'h1);
      if (n == 12) chk("majority_low", 2, 32'(oc[1]), 32'h0);
    end
    iv[2][1] = 1'b0;
    for (int n = 0; n < 8; n++) step();

    // Reset in the middle of a falling transition on channel 0.
    iv[0][0] = 1'b0;
    for (int e = 0; e <= 4; e++) step();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) model_reset(k);
    check_all();
    chk("midreset_o", 0, 32'(oa), 32'h7);
    chk("midreset_fall", 0, 32'(fa), 32'h0);
    iv[0][0] = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("no_fall_after_reset", 0, 32'(fa), 32'h0);
    end

    // Randomised phase against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        ch = int'($urandom_range(0, 2));
        iv[0][ch] = ~iv[0][ch];
      end
      if ($urandom_range(0, 39) == 0) begin
        ch = int'($urandom_range(0, 2));
        iv[1][ch] = ~iv[1][ch];
      end
      if ($urandom_range(0, 3) == 0) begin
        ch = int'($urandom_range(0, 2));
        iv[2][ch] = ~iv[2][ch];
      end
      if ($urandom_range(0, 14) == 0) hv[0] = ~hv[0];
      if ($urandom_range(0, 24) == 0) hv[1] = ~hv[1];
      if ($urandom_range(0, 14) == 0) hv[2] = ~hv[2];
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
